// File: rtl/pic_lite.sv
// pic_lite: lite programmable interrupt controller.
//   Latches falling edges of active-low irq lines into IRR, arbitrates by fixed
//   priority (index 0 highest) against IMR and the in-service levels in ISR,
//   and offers one vector at a time to the CPU over a valid/ready channel.
// Ports:
//   clk, resetn      - clock, asynchronous active-low reset
//   io_req_s_*       - 40-bit IO request stream ([32]=write, [17:16]=addr, [15:0]=data)
//   io_rd_m_*        - 16-bit registered read response stream
//   irq_in           - active-low interrupt request lines
//   intr_m_*         - interrupt vector {VBASE[7:3], index} to the CPU
// Register map: 0 IMR (R/W), 1 IRR (R, W1C), 2 ISR (R, any write = EOI), 3 VBASE.
// Build option: define PIC_LITE_SYNC_EN to add a 2-flop synchronizer on irq_in
//   (adds 2 cycles of irq latency) for asynchronous sources.
module pic_lite #(
  parameter int unsigned IRQ_CNT = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               io_req_s_tvalid,
  output logic               io_req_s_tready,
  input  logic [39:0]        io_req_s_tdata,
  output logic               io_rd_m_tvalid,
  input  logic               io_rd_m_tready,
  output logic [15:0]        io_rd_m_tdata,
  input  logic [IRQ_CNT-1:0] irq_in,
  output logic               intr_m_tvalid,
  input  logic               intr_m_tready,
  output logic [7:0]         intr_m_tdata
);

  localparam int unsigned IDX_W   = 3;
  localparam int unsigned VBASE_W = 5;

  typedef enum logic {
    ST_IDLE,
    ST_OFFER
  } state_e;

  state_e               state_q, state_d;
  logic [IRQ_CNT-1:0]   imr_q, imr_d;
  logic [IRQ_CNT-1:0]   irr_q, irr_d;
  logic [IRQ_CNT-1:0]   isr_q, isr_d;
  logic [VBASE_W-1:0]   vbase_q, vbase_d;
  logic [IRQ_CNT-1:0]   irq_prev_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 intr_tvalid_q, intr_tvalid_d;
  logic [7:0]           intr_tdata_q, intr_tdata_d;
  logic                 rd_tvalid_q, rd_tvalid_d;
  logic [15:0]          rd_tdata_q, rd_tdata_d;

  logic [IRQ_CNT-1:0]   irq_s;
  logic [IRQ_CNT-1:0]   irq_fall;
  logic                 req_fire, wr_en, rd_en;
  logic [1:0]           addr;
  logic [IRQ_CNT-1:0]   wdata;
  logic                 hs;
  logic [IRQ_CNT-1:0]   hs_mask;
  logic [IRQ_CNT-1:0]   isr_lsb, allowed, pend;
  logic                 cand_vld;
  logic [IDX_W-1:0]     cand_idx;
  logic                 unused_bits;

  // Optional input synchronizer
`ifdef PIC_LITE_SYNC_EN
  logic [IRQ_CNT-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // Falling-edge detect: a held-low level only fires once
  assign irq_fall = irq_prev_q & ~irq_s;

  // IO request decode; a request is taken whenever the response slot can move
  assign io_req_s_tready = !rd_tvalid_q || io_rd_m_tready;
  assign req_fire        = io_req_s_tvalid && io_req_s_tready;
  assign wr_en           = req_fire && io_req_s_tdata[32];
  assign rd_en           = req_fire && !io_req_s_tdata[32];
  assign addr            = io_req_s_tdata[17:16];
  assign wdata           = io_req_s_tdata[IRQ_CNT-1:0];
  assign unused_bits     = ^{io_req_s_tdata[39:33], io_req_s_tdata[31:18], io_req_s_tdata[15:0]};

  // Only indices strictly below the lowest in-service level may interrupt;
  // lsb-1 yields all ones when nothing is in service.
  assign isr_lsb = isr_q & (~isr_q + IRQ_CNT'(1));
  assign allowed = isr_lsb - IRQ_CNT'(1);
  assign pend    = irr_q & ~imr_q & allowed;

  // Fixed-priority pick: lowest index wins
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    for (int i = int'(IRQ_CNT) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        cand_vld = 1'b1;
        cand_idx = IDX_W'(i);
      end
    end
  end

  // Vector FSM: latch a candidate, hold it stable until the CPU accepts
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    intr_tvalid_d = intr_tvalid_q;
    intr_tdata_d  = intr_tdata_q;
    hs            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cand_vld) begin
          idx_d         = cand_idx;
          intr_tdata_d  = {vbase_q, cand_idx};
          intr_tvalid_d = 1'b1;
          state_d       = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (intr_m_tready) begin
          hs            = 1'b1;
          intr_tvalid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        intr_tvalid_d = 1'b0;
      end
    endcase
  end

  assign hs_mask = IRQ_CNT'(1) << idx_q;

  // Register file next state; new edges take precedence over any clear
  always_comb begin
    imr_d   = imr_q;
    irr_d   = irr_q;
    isr_d   = isr_q;
    vbase_d = vbase_q;
    if (wr_en) begin
      case (addr)
        2'd0: imr_d   = wdata;
        2'd1: irr_d   = irr_d & ~wdata;
        2'd2: isr_d   = isr_q & (isr_q - IRQ_CNT'(1));
        default: vbase_d = io_req_s_tdata[7:3];
      endcase
    end
    if (hs) begin
      irr_d = irr_d & ~hs_mask;
      isr_d = isr_d | hs_mask;
    end
    irr_d = irr_d | irq_fall;
  end

  // Read response slot
  always_comb begin
    rd_tvalid_d = rd_tvalid_q;
    rd_tdata_d  = rd_tdata_q;
    if (rd_en) begin
      rd_tvalid_d = 1'b1;
      case (addr)
        2'd0:    rd_tdata_d = 16'(imr_q);
        2'd1:    rd_tdata_d = 16'(irr_q);
        2'd2:    rd_tdata_d = 16'(isr_q);
        default: rd_tdata_d = {8'h00, vbase_q, 3'b000};
      endcase
    end else if (io_rd_m_tready) begin
      rd_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      imr_q         <= '1;
      irr_q         <= '0;
      isr_q         <= '0;
      vbase_q       <= VBASE_W'(1);
      irq_prev_q    <= '1;
      idx_q         <= '0;
      intr_tvalid_q <= 1'b0;
      intr_tdata_q  <= '0;
      rd_tvalid_q   <= 1'b0;
      rd_tdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      imr_q         <= imr_d;
      irr_q         <= irr_d;
      isr_q         <= isr_d;
      vbase_q       <= vbase_d;
      irq_prev_q    <= irq_s;
      idx_q         <= idx_d;
      intr_tvalid_q <= intr_tvalid_d;
      intr_tdata_q  <= intr_tdata_d;
      rd_tvalid_q   <= rd_tvalid_d;
      rd_tdata_q    <= rd_tdata_d;
    end
  end

  assign intr_m_tvalid  = intr_tvalid_q;
  assign intr_m_tdata   = intr_tdata_q;
  assign io_rd_m_tvalid = rd_tvalid_q;
  assign io_rd_m_tdata  = rd_tdata_q;

endmodule

// File: tb/tb_pic_lite.sv
// tb_pic_lite: directed self-checking bench for pic_lite.
//   Covers reset values, edge latching, masking, nesting/EOI, vector base,
//   level hold, read back-pressure, W1C vs. new edge, and reset during an offer.
module tb_pic_lite;

`ifdef PIC_LITE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk;
  logic        resetn;
  logic        io_req_s_tvalid;
  logic        io_req_s_tready;
  logic [39:0] io_req_s_tdata;
  logic        io_rd_m_tvalid;
  logic        io_rd_m_tready;
  logic [15:0] io_rd_m_tdata;
  logic [7:0]  irq_in;
  logic        intr_m_tvalid;
  logic        intr_m_tready;
  logic [7:0]  intr_m_tdata;

  int checks   = 0;
  int failures = 0;

  pic_lite #(.IRQ_CNT(8)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .io_req_s_tvalid (io_req_s_tvalid),
    .io_req_s_tready (io_req_s_tready),
    .io_req_s_tdata  (io_req_s_tdata),
    .io_rd_m_tvalid  (io_rd_m_tvalid),
    .io_rd_m_tready  (io_rd_m_tready),
    .io_rd_m_tdata   (io_rd_m_tdata),
    .irq_in          (irq_in),
    .intr_m_tvalid   (intr_m_tvalid),
    .intr_m_tready   (intr_m_tready),
    .intr_m_tdata    (intr_m_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic io_write(input logic [1:0] addr, input logic [15:0] data);
    int guard;
    io_req_s_tdata  = {7'd0, 1'b1, 14'd0, addr, data};
    io_req_s_tvalid = 1'b1;
    guard = 0;
    while (!io_req_s_tready && guard < 100) begin
      step(1);
      guard++;
    end
    step(1);
    io_req_s_tvalid = 1'b0;
  endtask

  task automatic io_read(input logic [1:0] addr, output logic [15:0] data);
    int guard;
    io_req_s_tdata  = {7'd0, 1'b0, 14'd0, addr, 16'd0};
    io_req_s_tvalid = 1'b1;
    guard = 0;
    while (!io_req_s_tready && guard < 100) begin
      step(1);
      guard++;
    end
    step(1);
    io_req_s_tvalid = 1'b0;
    guard = 0;
    while (!io_rd_m_tvalid && guard < 100) begin
      step(1);
      guard++;
    end
    data = io_rd_m_tdata;
    step(1);
  endtask

  task automatic read_chk(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    logic [15:0] d;
    io_read(addr, d);
    check_eq(tag, 32'(d), 32'(exp));
  endtask

  task automatic wait_tvalid(input string tag);
    int guard;
    guard = 0;
    while (!intr_m_tvalid && guard < 200) begin
      step(1);
      guard++;
    end
    if (!intr_m_tvalid) check_eq({tag, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic handshake();
    intr_m_tready = 1'b1;
    step(1);
    intr_m_tready = 1'b0;
  endtask

  task automatic pulse_irq(input logic [7:0] low_mask);
    irq_in = ~low_mask;
    step(1);
    irq_in = 8'hFF;
  endtask

  initial begin
    logic stable;
    int   seen;

    resetn          = 1'b0;
    io_req_s_tvalid = 1'b0;
    io_req_s_tdata  = '0;
    io_rd_m_tready  = 1'b1;
    irq_in          = 8'hFF;
    intr_m_tready   = 1'b0;
    step(3);
    check_eq("rst_intr_tvalid", 32'(intr_m_tvalid), 32'(0));
    check_eq("rst_intr_tdata", 32'(intr_m_tdata), 32'(0));
    check_eq("rst_rd_tvalid", 32'(io_rd_m_tvalid), 32'(0));
    resetn = 1'b1;
    step(1);

    // Reset register values
    read_chk("rst_imr", 2'd0, 16'h00FF);
    read_chk("rst_irr", 2'd1, 16'h0000);
    read_chk("rst_isr", 2'd2, 16'h0000);
    read_chk("rst_vbase", 2'd3, 16'h0008);

    // Masked edge latches but is not offered
    pulse_irq(8'h01);
    step(SYNC_LAT + 3);
    read_chk("masked_irr", 2'd1, 16'h0001);
    check_eq("masked_no_tvalid", 32'(intr_m_tvalid), 32'(0));
    io_write(2'd1, 16'h0001);
    read_chk("w1c_irr", 2'd1, 16'h0000);

    // Latency and stable offer under back-pressure
    io_write(2'd0, 16'h00FE);
    pulse_irq(8'h01);
    step(SYNC_LAT);
    check_eq("lat_early_tvalid", 32'(intr_m_tvalid), 32'(0));
    step(1);
    check_eq("lat_tvalid", 32'(intr_m_tvalid), 32'(1));
    check_eq("lat_tdata", 32'(intr_m_tdata), 32'h08);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (!intr_m_tvalid || intr_m_tdata !== 8'h08) stable = 1'b0;
    end
    check_eq("offer_stable", 32'(stable), 32'(1));
    handshake();
    check_eq("hs_tvalid_low", 32'(intr_m_tvalid), 32'(0));
    read_chk("hs_irr", 2'd1, 16'h0000);
    read_chk("hs_isr", 2'd2, 16'h0001);

    // Nesting: irq2 in service, then irq1+irq3 together
    io_write(2'd2, 16'h0000);
    read_chk("eoi_isr0", 2'd2, 16'h0000);
    io_write(2'd0, 16'h0000);
    pulse_irq(8'h04);
    wait_tvalid("irq2");
    check_eq("irq2_vec", 32'(intr_m_tdata), 32'h0A);
    handshake();
    read_chk("irq2_isr", 2'd2, 16'h0004);
    pulse_irq(8'h0A);
    wait_tvalid("irq1");
    check_eq("irq1_vec", 32'(intr_m_tdata), 32'h09);
    handshake();
    step(3);
    check_eq("irq3_blocked_a", 32'(intr_m_tvalid), 32'(0));
    read_chk("nest_isr", 2'd2, 16'h0006);
    io_write(2'd2, 16'h0000);
    read_chk("eoi1_isr", 2'd2, 16'h0004);
    read_chk("eoi1_irr", 2'd1, 16'h0008);
    check_eq("irq3_blocked_b", 32'(intr_m_tvalid), 32'(0));
    io_write(2'd2, 16'h0000);
    wait_tvalid("irq3");
    check_eq("irq3_vec", 32'(intr_m_tdata), 32'h0B);
    handshake();
    read_chk("irq3_isr", 2'd2, 16'h0008);
    io_write(2'd2, 16'h0000);

    // Vector base and held-low level
    io_write(2'd3, 16'h0070);
    read_chk("vbase_rd", 2'd3, 16'h0070);
    irq_in[5] = 1'b0;
    wait_tvalid("irq5");
    check_eq("irq5_vec", 32'(intr_m_tdata), 32'h75);
    handshake();
    io_write(2'd2, 16'h0000);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (intr_m_tvalid) seen++;
    end
    check_eq("level_no_retrig", 32'(seen), 32'(0));
    read_chk("level_irr", 2'd1, 16'h0000);
    irq_in[5] = 1'b1;
    step(2);

    // Read back-pressure
    io_rd_m_tready  = 1'b0;
    io_req_s_tdata  = {7'd0, 1'b0, 14'd0, 2'd3, 16'd0};
    io_req_s_tvalid = 1'b1;
    step(1);
    io_req_s_tvalid = 1'b0;
    check_eq("bp_rd_tvalid", 32'(io_rd_m_tvalid), 32'(1));
    check_eq("bp_req_tready", 32'(io_req_s_tready), 32'(0));
    step(3);
    check_eq("bp_req_tready_hold", 32'(io_req_s_tready), 32'(0));
    check_eq("bp_rd_data_hold", 32'(io_rd_m_tdata), 32'h0070);
    io_rd_m_tready = 1'b1;
    step(1);
    check_eq("bp_rd_released", 32'(io_rd_m_tvalid), 32'(0));
    check_eq("bp_req_tready_back", 32'(io_req_s_tready), 32'(1));

    // W1C of IRR[2] in the same cycle as a new irq2 edge
    io_write(2'd0, 16'h00FF);
    io_req_s_tdata  = {7'd0, 1'b1, 14'd0, 2'd1, 16'h0004};
    io_req_s_tvalid = 1'b1;
    irq_in[2]       = 1'b0;
    step(1);
    io_req_s_tvalid = 1'b0;
    irq_in[2]       = 1'b1;
    step(SYNC_LAT + 1);
    read_chk("w1c_vs_edge", 2'd1, 16'h0004);

    // Asynchronous reset while offering
    io_write(2'd0, 16'h00FB);
    wait_tvalid("pre_rst");
    check_eq("pre_rst_vec", 32'(intr_m_tdata), 32'h72);
    resetn = 1'b0;
    #1;
    check_eq("async_rst_tvalid", 32'(intr_m_tvalid), 32'(0));
    step(2);
    resetn = 1'b1;
    step(1);
    read_chk("rst2_imr", 2'd0, 16'h00FF);
    read_chk("rst2_irr", 2'd1, 16'h0000);
    read_chk("rst2_isr", 2'd2, 16'h0000);
    read_chk("rst2_vbase", 2'd3, 16'h0008);
    check_eq("rst2_tvalid", 32'(intr_m_tvalid), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
